otg_hpi_bus_sequencer: RTL and testbench



---
 rtl/otg_hpi_bus_sequencer.sv | 174 +++++++++++++++++
 tb/tb_otg_hpi_bus_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/otg_hpi_bus_sequencer.sv
// Turns each PIO strobe edge into one fixed-timing CY7C67200 HPI cycle (SETUP, STROBE, HOLD); build option OTG_HPI_ERR_CNT_EN counts protocol errors.
// Latency start edge -> WAIT_REL is SETUP_CYC+STROBE_CYC+HOLD_CYC+1; no backpressure, new strobes wait until both PIO strobes are released.
module otg_hpi_bus_sequencer #(
  parameter int unsigned SETUP_CYC  = 2,
  parameter int unsigned STROBE_CYC = 4,
  parameter int unsigned HOLD_CYC   = 2
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic [1:0]  hpi_address,
  input  logic        hpi_cs_n,
  input  logic        hpi_r_n,
  input  logic        hpi_w_n,
  input  logic [15:0] hpi_wdata,
  output logic [15:0] hpi_rdata,
  output logic        busy,
  output logic [7:0]  err_count,
  output logic [1:0]  otg_addr,
  output logic        otg_cs_n,
  output logic        otg_rd_n,
  output logic        otg_wr_n,
  output logic        otg_rst_n,
  inout  wire  [15:0] otg_data
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_WAIT_REL
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        r_prev_q, r_prev_d, w_prev_q, w_prev_d;
  logic        op_wr_q, op_wr_d;
  logic [1:0]  addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata_q, rdata_d;
  logic        cs_n_q, cs_n_d, rd_n_q, rd_n_d, wr_n_q, wr_n_d;
  logic        drive_q, drive_d, busy_q, busy_d;
  logic        rst_n_q, rst_n_d;
  logic        fell_r, fell_w, both_low;

  assign fell_r   = r_prev_q & ~hpi_r_n;
  assign fell_w   = w_prev_q & ~hpi_w_n;
  assign both_low = ~hpi_r_n & ~hpi_w_n;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    r_prev_d = hpi_r_n;
    w_prev_d = hpi_w_n;
    op_wr_d  = op_wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    rst_n_d  = reset_reset_n;

    case (state_q)
      S_IDLE: begin
        // Both strobes low is ambiguous: run no cycle, just wait for release.
        if (both_low) begin
          state_d = S_WAIT_REL;
        end else if (!hpi_cs_n && (fell_r ^ fell_w)) begin
          state_d = S_SETUP;
          cnt_d   = 4'(SETUP_CYC - 1);
          op_wr_d = fell_w;
          addr_d  = hpi_address;
          wdata_d = hpi_wdata;
        end
      end
      S_SETUP: begin
        if (cnt_q == 4'd0) begin
          state_d = S_STROBE;
          cnt_d   = 4'(STROBE_CYC - 1);
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_STROBE: begin
        if (cnt_q == 4'd0) begin
          if (!op_wr_q) rdata_d = otg_data;
          if (HOLD_CYC == 0) begin
            state_d = S_WAIT_REL;
          end else begin
            state_d = S_HOLD;
            cnt_d   = 4'(HOLD_CYC - 1);
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_HOLD: begin
        if (cnt_q == 4'd0) state_d = S_WAIT_REL;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_WAIT_REL: begin
        if (hpi_r_n && hpi_w_n) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Pin outputs are registered from the next state so the pins are glitch-free.
    busy_d  = (state_d == S_SETUP) || (state_d == S_STROBE) || (state_d == S_HOLD);
    cs_n_d  = ~busy_d;
    rd_n_d  = ~((state_d == S_STROBE) && !op_wr_d);
    wr_n_d  = ~((state_d == S_STROBE) && op_wr_d);
    drive_d = busy_d && op_wr_d;
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      r_prev_q <= 1'b1;
      w_prev_q <= 1'b1;
      op_wr_q  <= 1'b0;
      addr_q   <= 2'd0;
      wdata_q  <= 16'd0;
      rdata_q  <= 16'd0;
      cs_n_q   <= 1'b1;
      rd_n_q   <= 1'b1;
      wr_n_q   <= 1'b1;
      drive_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      r_prev_q <= r_prev_d;
      w_prev_q <= w_prev_d;
      op_wr_q  <= op_wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      cs_n_q   <= cs_n_d;
      rd_n_q   <= rd_n_d;
      wr_n_q   <= wr_n_d;
      drive_q  <= drive_d;
      busy_q   <= busy_d;
    end
  end

  // The chip reset follows the system reset one cycle later, including while in reset.
  always_ff @(posedge clk_clk) begin
    rst_n_q <= rst_n_d;
  end

`ifdef OTG_HPI_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if ((state_q == S_IDLE) && both_low && (err_cnt_q != 8'hFF))
      err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) err_cnt_q <= 8'd0;
    else                err_cnt_q <= err_cnt_d;
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = 8'd0;
`endif

  assign hpi_rdata = rdata_q;
  assign busy      = busy_q;
  assign otg_addr  = addr_q;
  assign otg_cs_n  = cs_n_q;
  assign otg_rd_n  = rd_n_q;
  assign otg_wr_n  = wr_n_q;
  assign otg_rst_n = rst_n_q;
  assign otg_data  = drive_q ? wdata_q : 16'hzzzz;

endmodule

// File: tb/tb_otg_hpi_bus_sequencer.sv
// Directed bench for otg_hpi_bus_sequencer: default-timing instance plus a SETUP=1/STROBE=1/HOLD=0 instance.
module tb_otg_hpi_bus_sequencer;

  logic        clk, rst_n;
  logic [1:0]  addr;
  logic        cs_n, r_n, w_n;
  logic [15:0] wdata;

  logic [15:0] rdata, rdata_c;
  logic        busy, busy_c;
  logic [7:0]  err, err_c;
  logic [1:0]  oaddr, oaddr_c;
  logic        ocs, ord, owr, orst;
  logic        ocs_c, ord_c, owr_c, orst_c;
  wire  [15:0] bus, bus_c;
  logic        tb_en, tb_en_c;
  logic [15:0] tb_val, tb_val_c;

  assign bus   = tb_en   ? tb_val   : 16'hzzzz;
  assign bus_c = tb_en_c ? tb_val_c : 16'hzzzz;

`ifdef OTG_HPI_ERR_CNT_EN
  localparam logic [7:0] ERR_ONE = 8'd1;
  localparam logic [7:0] ERR_SAT = 8'd255;
`else
  localparam logic [7:0] ERR_ONE = 8'd0;
  localparam logic [7:0] ERR_SAT = 8'd0;
`endif

  otg_hpi_bus_sequencer dut (
    .clk_clk(clk), .reset_reset_n(rst_n), .hpi_address(addr), .hpi_cs_n(cs_n),
    .hpi_r_n(r_n), .hpi_w_n(w_n), .hpi_wdata(wdata), .hpi_rdata(rdata),
    .busy(busy), .err_count(err), .otg_addr(oaddr), .otg_cs_n(ocs),
    .otg_rd_n(ord), .otg_wr_n(owr), .otg_rst_n(orst), .otg_data(bus)
  );

  otg_hpi_bus_sequencer #(.SETUP_CYC(1), .STROBE_CYC(1), .HOLD_CYC(0)) dut_c (
    .clk_clk(clk), .reset_reset_n(rst_n), .hpi_address(addr), .hpi_cs_n(cs_n),
    .hpi_r_n(r_n), .hpi_w_n(w_n), .hpi_wdata(wdata), .hpi_rdata(rdata_c),
    .busy(busy_c), .err_count(err_c), .otg_addr(oaddr_c), .otg_cs_n(ocs_c),
    .otg_rd_n(ord_c), .otg_wr_n(owr_c), .otg_rst_n(orst_c), .otg_data(bus_c)
  );

  int n_vec = 0;
  int n_mis = 0;

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    int cs_cnt, wr_cnt, wr_first, wr_last, busy_cnt, data_ok, addr_ok;
    int rd_cnt, rd_first, bus_bad, pulses, act;
    logic prev_wr;

    rst_n = 1'b0; cs_n = 1'b1; r_n = 1'b1; w_n = 1'b1; addr = 2'd0; wdata = 16'd0;
    tb_en = 1'b1; tb_val = 16'd0; tb_en_c = 1'b0; tb_val_c = 16'd0;
    repeat (3) tick();

    // Reset state
    expect_eq("rst_cs_n", 32'(ocs), 32'd1);
    expect_eq("rst_rd_n", 32'(ord), 32'd1);
    expect_eq("rst_wr_n", 32'(owr), 32'd1);
    expect_eq("rst_busy", 32'(busy), 32'd0);
    expect_eq("rst_rdata", 32'(rdata), 32'd0);
    expect_eq("rst_err", 32'(err), 32'd0);
    expect_eq("rst_addr", 32'(oaddr), 32'd0);
    expect_eq("rst_otg_rst_n", 32'(orst), 32'd0);
    expect_eq("rst_bus_released", 32'(bus), 32'd0);
    rst_n = 1'b1;
    tick();
    expect_eq("otg_rst_n_release", 32'(orst), 32'd1);
    tick();

    // Write: addr 2, 0xBEEF; inputs scrambled mid-cycle must be ignored
    cs_n = 1'b0; addr = 2'd2; wdata = 16'hBEEF; w_n = 1'b0; tb_en = 1'b0;
    cs_cnt = 0; wr_cnt = 0; wr_first = -1; wr_last = -1; busy_cnt = 0; data_ok = 0; addr_ok = 0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (!ocs) begin
        cs_cnt++;
        if (bus === 16'hBEEF) data_ok++;
        if (oaddr == 2'd2) addr_ok++;
      end
      if (!owr) begin
        wr_cnt++;
        if (wr_first < 0) wr_first = c;
        wr_last = c;
      end
      if (busy) busy_cnt++;
      if (c == 2) begin addr = 2'd3; wdata = 16'h0000; cs_n = 1'b1; end
      if (c == 9) begin
        tb_en = 1'b1; tb_val = 16'd0; #1;
        expect_eq("wr_bus_released_after", 32'(bus), 32'd0);
      end
    end
    expect_eq("wr_cs_low_cycles", cs_cnt, 8);
    expect_eq("wr_strobe_cycles", wr_cnt, 4);
    expect_eq("wr_strobe_first", wr_first, 3);
    expect_eq("wr_strobe_last", wr_last, 6);
    expect_eq("wr_busy_cycles", busy_cnt, 8);
    expect_eq("wr_data_held", data_ok, 8);
    expect_eq("wr_addr_held", addr_ok, 8);
    w_n = 1'b1; cs_n = 1'b1;
    tick(); tick();
    expect_eq("rdata_untouched_by_write", 32'(rdata), 32'd0);

    // Read: addr 1, chip returns 0x1234 only during the strobe window
    addr = 2'd1; wdata = 16'h00F0; cs_n = 1'b0; r_n = 1'b0; tb_en = 1'b1;
    rd_cnt = 0; rd_first = -1; bus_bad = 0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      tb_val = (c >= 3 && c <= 6) ? 16'h1234 : 16'h0000;
      #1;
      if (bus !== tb_val) bus_bad++;
      if (!ord) begin
        rd_cnt++;
        if (rd_first < 0) rd_first = c;
      end
      if (c == 3) expect_eq("rd_addr", 32'(oaddr), 32'd1);
      if (c == 6) expect_eq("rd_rdata_before", 32'(rdata), 32'd0);
      if (c == 7) expect_eq("rd_rdata_after", 32'(rdata), 32'h1234);
    end
    expect_eq("rd_strobe_cycles", rd_cnt, 4);
    expect_eq("rd_strobe_first", rd_first, 3);
    expect_eq("rd_bus_never_driven", bus_bad, 0);
    tb_val = 16'd0; r_n = 1'b1; cs_n = 1'b1;
    tick(); tick();

    // Long strobe then re-assert
    cs_n = 1'b0; wdata = 16'h1111; tb_en = 1'b0; w_n = 1'b0;
    pulses = 0; prev_wr = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      tick();
      if (prev_wr && !owr) pulses++;
      prev_wr = owr;
    end
    expect_eq("long_one_pulse", pulses, 1);
    expect_eq("long_busy_done", 32'(busy), 32'd0);
    w_n = 1'b1; tick(); tick();
    w_n = 1'b0;
    for (int c = 1; c <= 15; c++) begin
      tick();
      if (prev_wr && !owr) pulses++;
      prev_wr = owr;
    end
    expect_eq("long_second_pulse", pulses, 2);
    w_n = 1'b1; cs_n = 1'b1; tb_en = 1'b1;
    tick(); tick();

    // Protocol error: both strobes fall together
    cs_n = 1'b0; r_n = 1'b0; w_n = 1'b0; act = 0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (!ocs || !ord || !owr || busy) act++;
    end
    expect_eq("err_no_pin_activity", act, 0);
    expect_eq("err_count_one", 32'(err), 32'(ERR_ONE));
    r_n = 1'b1; w_n = 1'b1; tick(); tick();
    for (int i = 0; i < 299; i++) begin
      r_n = 1'b0; w_n = 1'b0; tick(); tick();
      r_n = 1'b1; w_n = 1'b1; tick(); tick();
    end
    expect_eq("err_count_sat", 32'(err), 32'(ERR_SAT));
    cs_n = 1'b1; tick();

    // Reset in the middle of a read strobe
    cs_n = 1'b0; addr = 2'd0; r_n = 1'b0; tb_val = 16'h5A5A;
    repeat (4) tick();
    expect_eq("mid_rst_in_strobe", 32'(ord), 32'd0);
    rst_n = 1'b0; r_n = 1'b1;
    tick();
    expect_eq("mid_rst_rd_n", 32'(ord), 32'd1);
    expect_eq("mid_rst_cs_n", 32'(ocs), 32'd1);
    expect_eq("mid_rst_busy", 32'(busy), 32'd0);
    expect_eq("mid_rst_rdata", 32'(rdata), 32'd0);
    expect_eq("mid_rst_otg_rst_n", 32'(orst), 32'd0);
    tb_val = 16'd0; #1;
    expect_eq("mid_rst_bus_released", 32'(bus), 32'd0);
    rst_n = 1'b1; tick(); tick();

    cs_n = 1'b0; wdata = 16'h0F0F; tb_en = 1'b0; w_n = 1'b0;
    cs_cnt = 0; wr_cnt = 0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (!ocs) cs_cnt++;
      if (!owr) wr_cnt++;
      if (c == 4) expect_eq("post_rst_data", 32'(bus), 32'h0F0F);
    end
    expect_eq("post_rst_cs_cycles", cs_cnt, 8);
    expect_eq("post_rst_wr_cycles", wr_cnt, 4);
    w_n = 1'b1; cs_n = 1'b1; tick(); tick();

    // Corner timing instance: SETUP=1, STROBE=1, HOLD=0
    cs_n = 1'b0; wdata = 16'hCAFE; w_n = 1'b0;
    cs_cnt = 0; wr_cnt = 0; wr_first = -1; data_ok = 0;
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (!ocs_c) cs_cnt++;
      if (!owr_c) begin
        wr_cnt++;
        if (wr_first < 0) wr_first = c;
      end
      if (c <= 2 && bus_c === 16'hCAFE) data_ok++;
      if (c == 3) begin
        tb_en_c = 1'b1; tb_val_c = 16'd0; #1;
        expect_eq("corner_bus_released", 32'(bus_c), 32'd0);
      end
    end
    expect_eq("corner_cs_cycles", cs_cnt, 2);
    expect_eq("corner_wr_cycles", wr_cnt, 1);
    expect_eq("corner_wr_first", wr_first, 2);
    expect_eq("corner_data", data_ok, 2);
    w_n = 1'b1; cs_n = 1'b1; tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
